// File: rtl/bitwise_sweep_pkg.sv
// Shared types and the reference operation for the bitwise gate sweep checkers.
// Latency: none (types and a pure function only).
// Backpressure: not applicable.
package bitwise_sweep_pkg;

  localparam int MAX_W = 8;

  typedef enum logic [1:0] {
    MODE_AND  = 2'b00,
    MODE_OR   = 2'b01,
    MODE_XOR  = 2'b10,
    MODE_NAND = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    DRIVE = 2'b01,
    DONE  = 2'b10
  } state_t;

  // Operands arrive zero-extended to MAX_W; callers truncate to their own width.
  function automatic logic [MAX_W-1:0] ref_op(input mode_t mode,
                                              input logic [MAX_W-1:0] a,
                                              input logic [MAX_W-1:0] b);
    logic [MAX_W-1:0] y;
    y = '0;
    case (mode)
      MODE_AND:  y = a & b;
      MODE_OR:   y = a | b;
      MODE_XOR:  y = a ^ b;
      MODE_NAND: y = ~(a & b);
      default:   y = '0;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/bitwise_ref_model.sv
// Combinational reference result for a 2-operand bitwise gate.
// Latency: 0 cycles.
// Backpressure: none; output follows inputs continuously.
module bitwise_ref_model
  import bitwise_sweep_pkg::*;
#(
  parameter int WIDTH = 2
) (
  input  mode_t            mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  assign y = WIDTH'(ref_op(mode, MAX_W'(a), MAX_W'(b)));

endmodule

// File: rtl/bitwise_sweep_checker.sv
// Exhaustive {b,a} stimulus sweep with per-vector compare against the reference.
// Latency: each vector held HOLD cycles; sample at the last cycle of its window.
// Backpressure: none; start ignored while busy, abort cancels at once.
module bitwise_sweep_checker
  import bitwise_sweep_pkg::*;
#(
  parameter int WIDTH   = 2,
  parameter int HOLD    = 10,
  parameter int DUT_LAT = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [1:0]         mode,
  output logic [WIDTH-1:0]   stim_a,
  output logic [WIDTH-1:0]   stim_b,
  input  logic [WIDTH-1:0]   dut_v,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [2*WIDTH:0]   err_cnt,
  output logic [2*WIDTH-1:0] first_err_idx
);

  localparam int IW  = 2 * WIDTH;
  localparam int HCW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD - 1);
  localparam logic [IW-1:0]  IDX_LAST  = '1;

  // Shorter windows are allowed on purpose: they sample stale results and
  // are the way to show that a given latency does not fit in the window.
  if (HOLD <= DUT_LAT) begin : g_short_window
  end

  state_t           state_q, state_d;
  mode_t            mode_q;
  logic [IW-1:0]    idx_q;
  logic [HCW-1:0]   hold_q;
  logic [IW:0]      err_q;
  logic [IW-1:0]    first_q;
  logic [WIDTH-1:0] ref_v;
  logic             sample;
  logic             accept;
  logic             mismatch;

  bitwise_ref_model #(.WIDTH(WIDTH)) u_ref (
    .mode (mode_q),
    .a    (stim_a),
    .b    (stim_b),
    .y    (ref_v)
  );

  assign sample   = (state_q == DRIVE) && (hold_q == HOLD_LAST);
  assign accept   = start && !abort && (state_q != DRIVE);
  // Case inequality so an unknown DUT bit scores as a failure.
  assign mismatch = (dut_v !== ref_v);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = DRIVE;
      DRIVE:   if (sample && (idx_q == IDX_LAST)) state_d = DONE;
      DONE:    if (start) state_d = DRIVE;
      default: state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q  <= MODE_AND;
      idx_q   <= '0;
      hold_q  <= '0;
      err_q   <= '0;
      first_q <= '0;
    end else if (abort) begin
      idx_q  <= '0;
      hold_q <= '0;
    end else if (accept) begin
      mode_q <= mode_t'(mode);
      idx_q  <= '0;
      hold_q <= '0;
      err_q  <= '0;
    end else if (state_q == DRIVE) begin
      if (sample) begin
        hold_q <= '0;
        idx_q  <= idx_q + 1'b1;
        if (mismatch) begin
          err_q <= err_q + 1'b1;
          if (err_q == '0) first_q <= idx_q;
        end
      end else begin
        hold_q <= hold_q + 1'b1;
      end
    end
  end

  assign busy          = (state_q == DRIVE);
  assign done          = (state_q == DONE);
  assign pass          = done && (err_q == '0);
  assign stim_a        = busy ? idx_q[WIDTH-1:0]  : '0;
  assign stim_b        = busy ? idx_q[IW-1:WIDTH] : '0;
  assign err_cnt       = err_q;
  assign first_err_idx = first_q;

endmodule

// File: tb/tb_bitwise_sweep_checker.sv
// Directed bench for bitwise_sweep_checker: sweep timing, scoring, abort, reset, latency windows.
module tb_bitwise_sweep_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [1:0] mode = 2'b00;
  logic       stuck = 1'b0;
  logic [1:0] stim_a, stim_b, dut_v;
  logic       busy, done, pass;
  logic [4:0] err_cnt;
  logic [3:0] first_err_idx;

  // Latency instances: 3-stage registered AND DUT, HOLD=4 (fits) and HOLD=3 (too short).
  logic       start6 = 1'b0;
  logic       abort6 = 1'b0;
  logic [1:0] sa4, sb4, sa3, sb3;
  logic [1:0] p4 [3];
  logic [1:0] p3 [3];
  logic       busy4, done4, pass4, busy3, done3, pass3;
  logic [4:0] err4, err3;
  logic [3:0] fe4, fe3;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign dut_v = stuck ? 2'b00 : (stim_a & stim_b);

  bitwise_sweep_checker #(.WIDTH(2), .HOLD(10), .DUT_LAT(0)) u_dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode),
    .stim_a(stim_a), .stim_b(stim_b), .dut_v(dut_v),
    .busy(busy), .done(done), .pass(pass),
    .err_cnt(err_cnt), .first_err_idx(first_err_idx)
  );

  bitwise_sweep_checker #(.WIDTH(2), .HOLD(4), .DUT_LAT(3)) u_lat4 (
    .clk(clk), .rst(rst), .start(start6), .abort(abort6), .mode(2'b00),
    .stim_a(sa4), .stim_b(sb4), .dut_v(p4[2]),
    .busy(busy4), .done(done4), .pass(pass4),
    .err_cnt(err4), .first_err_idx(fe4)
  );

  bitwise_sweep_checker #(.WIDTH(2), .HOLD(3), .DUT_LAT(3)) u_lat3 (
    .clk(clk), .rst(rst), .start(start6), .abort(abort6), .mode(2'b00),
    .stim_a(sa3), .stim_b(sb3), .dut_v(p3[2]),
    .busy(busy3), .done(done3), .pass(pass3),
    .err_cnt(err3), .first_err_idx(fe3)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        p4[i] <= 2'b00;
        p3[i] <= 2'b00;
      end
    end else begin
      p4[0] <= sa4 & sb4;
      p4[1] <= p4[0];
      p4[2] <= p4[1];
      p3[0] <= sa3 & sb3;
      p3[1] <= p3[0];
      p3[2] <= p3[1];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Pulse start across one rising edge; returns at the negedge right after acceptance.
  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts edges until done, checking the vector index seen after each edge.
  task automatic wait_done(output int cyc, output int order_bad);
    int c;
    c = 0;
    order_bad = 0;
    if ({stim_b, stim_a} !== 4'd0) order_bad++;
    while (!done && c < 400) begin
      @(negedge clk);
      c++;
      if (c < 160 && ({stim_b, stim_a} !== 4'(c / 10))) order_bad++;
    end
    cyc = c;
  endtask

  initial begin
    int cyc, obad, to;

    // Reset values
    #2 rst = 1'b1;
    #10 rst = 1'b0;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_err", err_cnt, 0);
    check("rst_first", first_err_idx, 0);
    check("rst_stim", {stim_b, stim_a}, 0);

    // 1. Correct AND DUT
    mode = 2'b00; stuck = 1'b0;
    pulse_start();
    check("t1_busy", busy, 1);
    wait_done(cyc, obad);
    check("t1_cycles", cyc, 160);
    check("t1_order", obad, 0);
    check("t1_err", err_cnt, 0);
    check("t1_pass", pass, 1);
    check("t1_stim_idle", {stim_b, stim_a}, 0);

    // 2. Stuck-at-zero DUT, AND mode
    stuck = 1'b1;
    pulse_start();
    wait_done(cyc, obad);
    check("t2_err", err_cnt, 7);
    check("t2_first", first_err_idx, 5);
    check("t2_pass", pass, 0);
    check("t2_done", done, 1);

    // 3. AND DUT scored as XOR
    stuck = 1'b0; mode = 2'b10;
    pulse_start();
    mode = 2'b00;
    wait_done(cyc, obad);
    check("t3_err", err_cnt, 15);
    check("t3_first", first_err_idx, 1);
    check("t3_pass", pass, 0);

    // 4. Abort at vector 6 with stuck DUT (idx 5 already failed), then rerun
    stuck = 1'b1; mode = 2'b00;
    pulse_start();
    to = 0;
    while ({stim_b, stim_a} != 4'd6 && to < 200) begin
      @(negedge clk);
      to++;
    end
    check("t4_reach6", {stim_b, stim_a}, 6);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("t4_busy", busy, 0);
    check("t4_done", done, 0);
    check("t4_stim", {stim_b, stim_a}, 0);
    check("t4_err_kept", err_cnt, 1);
    check("t4_first_kept", first_err_idx, 5);
    stuck = 1'b0;
    pulse_start();
    check("t4_err_clr", err_cnt, 0);
    wait_done(cyc, obad);
    check("t4_cycles", cyc, 160);
    check("t4_order", obad, 0);
    check("t4_pass", pass, 1);

    // abort beats start in DONE
    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("t4_ab_busy", busy, 0);
    check("t4_ab_done", done, 0);

    // 5a. start while busy and mode toggles are ignored
    mode = 2'b00;
    pulse_start();
    repeat (30) @(negedge clk);
    mode = 2'b10;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t5_stim_cont", {stim_b, stim_a}, 3);
    mode = 2'b01;
    to = 0;
    while (!done && to < 400) begin
      @(negedge clk);
      to++;
    end
    check("t5_cycles_rem", to, 129);
    check("t5_err", err_cnt, 0);
    check("t5_pass", pass, 1);

    // 5b. asynchronous reset mid-sweep with errors already counted
    stuck = 1'b1; mode = 2'b00;
    pulse_start();
    repeat (70) @(negedge clk);
    check("t5_pre_err", (err_cnt != 0), 1);
    #2 rst = 1'b1;
    #1;
    check("t5_rst_busy", busy, 0);
    check("t5_rst_done", done, 0);
    check("t5_rst_pass", pass, 0);
    check("t5_rst_err", err_cnt, 0);
    check("t5_rst_first", first_err_idx, 0);
    check("t5_rst_stim", {stim_b, stim_a}, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("t5_no_done", done, 0);

    // 6. Registered DUT with 3-cycle latency
    @(negedge clk);
    start6 = 1'b1;
    @(negedge clk);
    start6 = 1'b0;
    to = 0;
    while (!(done4 && done3) && to < 200) begin
      @(negedge clk);
      to++;
    end
    check("t6_done4", done4, 1);
    check("t6_done3", done3, 1);
    check("t6_pass4", pass4, 1);
    check("t6_err4", err4, 0);
    check("t6_err3_nz", (err3 != 0), 1);
    check("t6_pass3", pass3, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
